// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/data inputs and grant/select/data outputs of the shared mux arbiter
interface mux_rr_arbiter_if #(parameter int N = 16, parameter int SEL_W = 4, parameter int HW = 4);
  logic [N-1:0]     req;
  logic [N-1:0]     data_in;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     gnt;
  logic             valid;
  logic             y;
  logic [HW-1:0]    hold_cnt;
  modport master (output req, data_in, input sel, gnt, valid, y, hold_cnt);
  modport slave  (input req, data_in, output sel, gnt, valid, y, hold_cnt);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one N:1 bit mux with a bounded per-grant hold
module mux_rr_arbiter #(
  parameter int N = 16,
  parameter int SEL_W = $clog2(N),
  parameter int MAX_HOLD = 8,
  parameter int HW = $clog2(MAX_HOLD) + 1
) (
  input logic clk,
  input logic rst_n,
  mux_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state;
  logic [SEL_W-1:0] r_ptr, r_sel, w_base, w_win;
  logic [N-1:0] r_gnt;
  logic r_valid, w_rel, w_found;
  logic [HW-1:0] r_hold;
  assign w_rel = (r_state == GRANT) && (!bus.req[r_sel] || r_hold == HW'(MAX_HOLD - 1));
  // on release the search starts just past the grantee, matching the pointer update on the same edge
  assign w_base = w_rel ? r_sel + SEL_W'(1) : r_ptr;
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (bus.req[w_base + SEL_W'(k)]) begin
        w_found = 1'b1;
        w_win = w_base + SEL_W'(k);
      end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_sel <= '0;
      r_gnt <= '0;
      r_valid <= 1'b0;
      r_hold <= '0;
    end else if (r_state == IDLE || w_rel) begin
      if (w_rel) r_ptr <= r_sel + SEL_W'(1);
      r_state <= w_found ? GRANT : IDLE;
      r_sel <= w_found ? w_win : r_sel;
      r_gnt <= w_found ? N'(1) << w_win : '0;
      r_valid <= w_found;
      r_hold <= '0;
    end else
      r_hold <= r_hold + HW'(1);
  end
  assign bus.sel = r_sel;
  assign bus.gnt = r_gnt;
  assign bus.valid = r_valid;
  assign bus.hold_cnt = r_hold;
  assign bus.y = r_valid ? bus.data_in[r_sel] : 1'b0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench with an integer-level round-robin reference model
module tb_mux_rr_arbiter;
  localparam int N = 16, MAX_HOLD = 8;
  typedef struct {
    logic [15:0] gnt;
    logic [3:0] sel;
    logic valid;
    logic [3:0] hold;
    bit chk_sel;
  } exp_t;
  logic clk = 0, rst_n = 0;
  int total = 0, bad = 0;
  int m_owner = -1, m_ptr = 0, m_held = 0, m_sel = 0;
  exp_t q[$];
  mux_rr_arbiter_if #(.N(16), .SEL_W(4), .HW(4)) bus();
  mux_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(bit rs, logic [15:0] r, logic [15:0] d);
    exp_t e;
    @(negedge clk);
    rst_n = rs;
    bus.req = r;
    bus.data_in = d;
    if (!rs) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0;
    end else if (m_owner < 0 || !r[m_owner] || m_held == MAX_HOLD - 1) begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
      m_owner = -1;
      m_held = 0;
      for (int o = 0; o < N; o++)
        if (m_owner < 0 && r[(m_ptr + o) % N]) m_owner = (m_ptr + o) % N;
    end else m_held++;
    if (m_owner >= 0) m_sel = m_owner;
    e.gnt = m_owner >= 0 ? 16'(1) << m_owner : 16'h0;
    e.valid = m_owner >= 0;
    e.sel = 4'(m_sel);
    e.hold = 4'(m_held);
    e.chk_sel = m_owner >= 0 || !rs;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic ey;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("gnt", 32'(bus.gnt), 32'(e.gnt));
        check("valid", 32'(bus.valid), 32'(e.valid));
        check("hold_cnt", 32'(bus.hold_cnt), 32'(e.hold));
        if (e.chk_sel) check("sel", 32'(bus.sel), 32'(e.sel));
        check("onehot", 32'($onehot0(bus.gnt) && (bus.valid == (bus.gnt != 0))), 32'(1));
        ey = e.valid ? bus.data_in[e.sel] : 1'b0;
        check("y_edge", 32'(bus.y), 32'(ey));
        @(negedge clk);
        #1;
        ey = e.valid ? bus.data_in[e.sel] : 1'b0;
        check("y_mid", 32'(bus.y), 32'(ey));
      end
    end
  end

  initial begin
    bus.req = '0;
    bus.data_in = '0;
    repeat (2) step(0, 16'hFFFF, 16'h0);
    step(1, 16'hFFFF, 16'h0);
    repeat (20) step(1, 16'h0001, 16'h0001);
    step(0, 16'h0, 16'h0);
    repeat (40) step(1, 16'h8421, 16'($urandom));
    step(0, 16'h0, 16'h0);
    repeat (3) step(1, 16'h0008, 16'($urandom));
    step(1, 16'h0000, 16'($urandom));
    repeat (3) step(1, 16'h0004, 16'($urandom));
    step(0, 16'h0, 16'h0);
    step(1, 16'h0400, 16'h0);
    for (int i = 0; i < 8; i++) step(1, 16'h0400, (16'($urandom) & ~16'h0400) | (16'(i & 1) << 10));
    step(0, 16'h0, 16'h0);
    repeat (5) step(1, 16'h0080, 16'($urandom));
    step(0, 16'h0081, 16'hFFFF);
    repeat (3) step(1, 16'h0081, 16'hFFFF);
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 63) != 0), 16'($urandom) & 16'($urandom) & 16'($urandom), 16'($urandom));
    repeat (2) @(negedge clk);
    check("drain", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
